fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS core; directly upstream of the 128x32 instruction Ram (flag=1).
//  Owns the PC and drives the Ram word address with wre held high (read-only).
//  Registers the returned word plus PC+4 into the IF/ID pipeline register.
//  Handles decode-stage stalls, EX-resolved branch/jump redirects and misaligned-target faults.
// PARAMETERS
//  ADDR_W         7       Ram word-address width (128 words); imem_addr = pc[ADDR_W+1:2]
//  RESET_PC       32'h0   PC value loaded on reset
//  WARMUP_CYCLES  2       cycles after reset release before first fetch (Ram init settles); range 1..15
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  imem_addr      out  ADDR_W  word address to instruction Ram
//  imem_data      in   32      read data from instruction Ram (combinational, same cycle)
//  imem_wre       out  1       Ram write enable; constant 1 (read)
//  stall          in   1       hold PC and IF/ID (load-use hazard from ID)
//  branch_taken   in   1       redirect request from EX, one-cycle pulse
//  branch_target  in   32      byte address of redirect, valid with branch_taken
//  pc             out  32      current fetch PC
//  if_id_instr    out  32      registered instruction
//  if_id_pc4      out  32      registered PC+4 of that instruction
//  if_id_valid    out  1       IF/ID holds a real instruction (0 = bubble, instr = 32'h0 nop)
//  fetch_fault    out  1       sticky: misaligned redirect target seen
// BEHAVIOUR
//  Reset (async, reset==0): pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_fault=0,
//   state=WARMUP, warm_cnt=0, pend_valid=0. Applies immediately, mid-operation included.
//  FSM: WARMUP -> RUN when warm_cnt==WARMUP_CYCLES-1; RUN -> HALT on misaligned target; HALT exits only by reset.
//  WARMUP: pc held, if_id_valid=0, branch_taken/stall ignored.
//  RUN, per edge, priority high->low:
//   1 branch_taken & branch_target[1:0]!=0: fetch_fault<=1, state<=HALT, if_id_valid<=0, if_id_instr<=0.
//   2 branch_taken: pc<=branch_target; IF/ID flushed (valid<=0, instr<=0, pc4<=0). Overrides stall.
//   3 stall: pc, IF/ID unchanged.
//   4 else: if_id_instr<=imem_data, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4.
//  Latency: word at pc appears on if_id_instr one edge after pc is presented; throughput 1/cycle.
//  Arithmetic: pc+4 modulo 2^32; imem_addr ignores bits above ADDR_W+1, so fetch wraps word 127 -> word 0.
//  HALT: pc frozen, if_id_valid=0, fetch_fault=1; all inputs ignored.
//  imem_wre is 1 in every state including reset.
// CONFIGURATION
//  Macro FETCH_DELAY_SLOT_EN:
//   undefined: behaviour above; instruction after a taken branch is squashed.
//   defined: redirect (rule 2) does not flush; IF/ID loads the delay-slot word at pc (valid=1) and pc<=target.
//    branch_taken & stall together: target latched in pend_target, pend_valid<=1, pc/IF/ID held;
//    first non-stall cycle loads delay slot and sets pc<=pend_target, pend_valid<=0.
//    New branch_taken while pend_valid replaces pend_target. Misalignment checked at latch time (rule 1).
// TESTING
//  1 reset low 3 cycles, release -> pc=0, if_id_valid=0 for 2 edges; third edge if_id_instr=mem[0], pc=4, pc4=4.
//  2 Ram words 1,2 = 32'h2129000A, 32'h214A0005; run -> consecutive edges give those words, pc4 = 8, 12.
//  3 stall high 2 cycles at pc=8 -> pc, if_id_instr, if_id_pc4 frozen; resume fetches mem[2] next edge.
//  4 branch_taken, target=32'h10 at pc=12 -> next edge pc=16, valid=0, instr=0 (with _EN: valid=1, instr=mem[3]).
//  5 branch_taken & stall same edge, target 32'h20 -> pc=32h20, valid=0 (with _EN: held, then delay slot + pc=32h20).
//  6 target 32'h0000_0006 -> fetch_fault=1, valid=0, pc frozen; reset clears fault, pc=0.
//  7 branch to 32'h1FC -> imem_addr=127; next pc=32'h200, imem_addr=0 (wrap).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction Ram and fills IF/ID.
// Optional macro FETCH_DELAY_SLOT_EN keeps the word after a taken branch (delay slot).
module fetch_stage #(
   parameter int          ADDR_W        = 7,
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter int          WARMUP_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              imem_wre,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   output logic [31:0]       pc,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic              fetch_fault
);

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      HALT   = 2'd2
   } state_t;

   localparam logic [3:0] WARM_LAST = 4'(WARMUP_CYCLES - 1);

   state_t      state;
   logic [3:0]  warm_cnt;
   logic [31:0] pc_next;
   logic        misaligned;

`ifdef FETCH_DELAY_SLOT_EN
   logic [31:0] pend_target;
   logic        pend_valid;
`endif

   // Ram is read-only from this stage; word address drops byte bits
   assign imem_wre   = 1'b1;
   assign imem_addr  = pc[ADDR_W+1:2];
   assign pc_next    = pc + 32'd4;
   assign misaligned = branch_taken & (branch_target[1:0] != 2'b00);

   // PC, IF/ID register and control FSM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= WARMUP;
         warm_cnt    <= 4'd0;
         pc          <= RESET_PC;
         if_id_instr <= 32'h0;
         if_id_pc4   <= 32'h0;
         if_id_valid <= 1'b0;
         fetch_fault <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
         pend_target <= 32'h0;
         pend_valid  <= 1'b0;
`endif
      end else begin
         unique case (state)
            WARMUP: begin
               if_id_valid <= 1'b0;
               if (warm_cnt == WARM_LAST)
                  state <= RUN;
               else
                  warm_cnt <= warm_cnt + 4'd1;
            end
            RUN: begin
`ifndef FETCH_DELAY_SLOT_EN
               if (misaligned) begin
                  fetch_fault <= 1'b1;
                  state       <= HALT;
                  if_id_valid <= 1'b0;
                  if_id_instr <= 32'h0;
               end else if (branch_taken) begin
                  pc          <= branch_target;
                  if_id_valid <= 1'b0;
                  if_id_instr <= 32'h0;
                  if_id_pc4   <= 32'h0;
               end else if (!stall) begin
                  if_id_instr <= imem_data;
                  if_id_pc4   <= pc_next;
                  if_id_valid <= 1'b1;
                  pc          <= pc_next;
               end
`else
               if (misaligned) begin
                  fetch_fault <= 1'b1;
                  state       <= HALT;
                  if_id_valid <= 1'b0;
                  if_id_instr <= 32'h0;
                  pend_valid  <= 1'b0;
               end else if (branch_taken && stall) begin
                  pend_target <= branch_target;
                  pend_valid  <= 1'b1;
               end else if (branch_taken) begin
                  if_id_instr <= imem_data;
                  if_id_pc4   <= pc_next;
                  if_id_valid <= 1'b1;
                  pc          <= branch_target;
                  pend_valid  <= 1'b0;
               end else if (stall) begin
                  pend_valid <= pend_valid;
               end else if (pend_valid) begin
                  if_id_instr <= imem_data;
                  if_id_pc4   <= pc_next;
                  if_id_valid <= 1'b1;
                  pc          <= pend_target;
                  pend_valid  <= 1'b0;
               end else begin
                  if_id_instr <= imem_data;
                  if_id_pc4   <= pc_next;
                  if_id_valid <= 1'b1;
                  pc          <= pc_next;
               end
`endif
            end
            HALT: begin
               if_id_valid <= 1'b0;
               fetch_fault <= 1'b1;
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized run
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam int WARM = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  imem_addr;
   logic [31:0] imem_data;
   logic        imem_wre;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_fault;

   logic [31:0] mem [128];

   int checks = 0;
   int failures = 0;

   fetch_stage #(
      .ADDR_W(7), .RESET_PC(32'h0), .WARMUP_CYCLES(WARM)
   ) dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_wre(imem_wre), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid), .fetch_fault(fetch_fault)
   );

   always #5 clock = ~clock;

   assign imem_data = mem[imem_addr];

   // behavioural model
   int          m_edges;
   bit          m_halt;
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_fault;

   function automatic void model_reset();
      m_edges = 0; m_halt = 0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0;
   endfunction

   function automatic void model_step(bit s, bit b, logic [31:0] t);
      if (m_halt) return;
      if (m_edges < WARM) begin
         m_edges++;
         return;
      end
      if (b && t[1:0] != 2'b00) begin
         m_fault = 1; m_halt = 1; m_valid = 0; m_instr = 0;
      end else if (b) begin
         m_pc = t; m_valid = 0; m_instr = 0; m_pc4 = 0;
      end else if (!s) begin
         m_instr = mem[(m_pc / 4) % 128];
         m_pc = m_pc + 4;
         m_pc4 = m_pc;
         m_valid = 1;
      end
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".addr"}, {25'h0, imem_addr}, (m_pc / 4) % 128);
      chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
      chk({tag, ".instr"}, if_id_instr, m_instr);
      if (!m_halt) chk({tag, ".pc4"}, if_id_pc4, m_pc4);
      chk({tag, ".fault"}, {31'h0, fetch_fault}, {31'h0, m_fault});
      chk({tag, ".wre"}, {31'h0, imem_wre}, 32'h1);
   endtask

   // asynchronous reset applied between edges, checked before any edge
   task automatic do_reset(string tag);
      reset = 1'b0;
      #2;
      model_reset();
      chk_model({tag, ".async"});
      tick();
      reset = 1'b1;
   endtask

   typedef struct {
      bit          s;
      bit          b;
      logic [31:0] t;
      logic [31:0] pc;
      bit          v;
      logic [31:0] instr;
      logic [31:0] pc4;
      bit          c4;
      bit          f;
      logic [6:0]  addr;
   } vec_t;

   vec_t vt [16];

   function automatic vec_t mk(bit s, bit b, logic [31:0] t,
                               logic [31:0] p, bit v,
                               logic [31:0] i, logic [31:0] p4,
                               bit c4, bit f);
      vec_t r;
      r.s = s; r.b = b; r.t = t; r.pc = p; r.v = v;
      r.instr = i; r.pc4 = p4; r.c4 = c4; r.f = f;
      r.addr = p[8:2];
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + i;
      mem[1] = 32'h2129_000A;
      mem[2] = 32'h214A_0005;

      vt[0]  = mk(0, 0, 0,      32'h0,   0, 0,       0,       1, 0);
      vt[1]  = mk(0, 0, 0,      32'h0,   0, 0,       0,       1, 0);
      vt[2]  = mk(0, 0, 0,      32'h4,   1, mem[0],  32'h4,   1, 0);
      vt[3]  = mk(0, 0, 0,      32'h8,   1, mem[1],  32'h8,   1, 0);
      vt[4]  = mk(1, 0, 0,      32'h8,   1, mem[1],  32'h8,   1, 0);
      vt[5]  = mk(1, 0, 0,      32'h8,   1, mem[1],  32'h8,   1, 0);
      vt[6]  = mk(0, 0, 0,      32'hC,   1, mem[2],  32'hC,   1, 0);
      vt[7]  = mk(0, 1, 32'h10, 32'h10,  0, 0,       0,       1, 0);
      vt[8]  = mk(0, 0, 0,      32'h14,  1, mem[4],  32'h14,  1, 0);
      vt[9]  = mk(1, 1, 32'h20, 32'h20,  0, 0,       0,       1, 0);
      vt[10] = mk(0, 0, 0,      32'h24,  1, mem[8],  32'h24,  1, 0);
      vt[11] = mk(0, 1, 32'h1FC,32'h1FC, 0, 0,       0,       1, 0);
      vt[12] = mk(0, 0, 0,      32'h200, 1, mem[127],32'h200, 1, 0);
      vt[13] = mk(0, 0, 0,      32'h204, 1, mem[0],  32'h204, 1, 0);
      vt[14] = mk(0, 1, 32'h6,  32'h204, 0, 0,       0,       0, 1);
      vt[15] = mk(1, 1, 32'h40, 32'h204, 0, 0,       0,       0, 1);

      // reset held three cycles
      #1;
      chk("rst.pc", pc, 32'h0);
      chk("rst.valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst.wre", {31'h0, imem_wre}, 32'h1);
      repeat (3) tick();
      reset = 1'b1;

      for (int k = 0; k < 16; k++) begin
         stall = vt[k].s;
         branch_taken = vt[k].b;
         branch_target = vt[k].t;
         tick();
         chk($sformatf("v%0d.pc", k), pc, vt[k].pc);
         chk($sformatf("v%0d.addr", k), {25'h0, imem_addr},
             {25'h0, vt[k].addr});
         chk($sformatf("v%0d.valid", k), {31'h0, if_id_valid},
             {31'h0, vt[k].v});
         chk($sformatf("v%0d.instr", k), if_id_instr, vt[k].instr);
         if (vt[k].c4)
            chk($sformatf("v%0d.pc4", k), if_id_pc4, vt[k].pc4);
         chk($sformatf("v%0d.fault", k), {31'h0, fetch_fault},
             {31'h0, vt[k].f});
      end

      // reset clears the sticky fault immediately
      stall = 0; branch_taken = 0; branch_target = 0;
      do_reset("halt_rst");

      // mid-run reset: advance into RUN, then reset between edges
      repeat (5) begin
         tick();
         model_step(0, 0, 0);
      end
      chk_model("pre_mid");
      do_reset("mid_rst");

      // randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         stall = ($urandom % 4) == 0;
         branch_taken = ($urandom % 6) == 0;
         r = $urandom % 64;
         if (r == 0)
            branch_target = $urandom | 32'h1;
         else if (r < 4)
            branch_target = 32'hFFFF_FFF0 + 4 * $urandom_range(0, 3);
         else
            branch_target = $urandom_range(0, 1023) << 2;
         tick();
         model_step(stall, branch_taken, branch_target);
         chk_model("rnd");
         if ((m_halt && ($urandom % 8) == 0) || ($urandom % 400) == 0) begin
            stall = 0; branch_taken = 0;
            do_reset("rnd_rst");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
